// File: rtl/tdl_ctrl_pkg.sv
// Shared types and default cycle counts for the TDL link sequencers.
// Latency: n/a (package only).
// Backpressure: n/a.
package tdl_ctrl_pkg;

    // Sequencer states; codes 5-7 are illegal and recover to S_RESET
    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LINK = 3'd1,
        S_DP_RESET  = 3'd2,
        S_LINKED    = 3'd3,
        S_FAULT     = 3'd4
    } tdl_state_t;

    // Defaults shared by the FMC0 and FMC1 instances
    localparam int unsigned TDL_RESET_CYCLES     = 1000;
    localparam int unsigned TDL_DP_RESET_CYCLES  = 100;
    localparam int unsigned TDL_LINK_TIMEOUT     = 1000000;
    localparam int unsigned TDL_STABLE_CYCLES    = 1024;
    localparam int unsigned TDL_MAX_DP_RETRIES   = 3;
    localparam int unsigned TDL_MAX_FULL_RETRIES = 4;
    localparam int unsigned TDL_LOSS_W           = 8;

    // Largest of three cycle counts, used to size the shared timer
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tdl_sync2.sv
// Two-flop synchroniser for an async level, optionally emitting a one-cycle rising-edge pulse.
// Latency: 2 cycles pin to output (edge pulse is combinational on the synchronised value).
// Backpressure: none; free-running.
module tdl_sync2 #(
    parameter bit EDGE_OUT = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    generate
        if (EDGE_OUT) begin : g_edge
            logic r_prev;
            // Remember last synchronised value for rising-edge detection
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_prev <= 1'b0;
                else          r_prev <= r_sync;
            end
            assign o_sync = r_sync & ~r_prev;
        end else begin : g_level
            assign o_sync = r_sync;
        end
    endgenerate

endmodule

// File: rtl/tdl_link_sequencer.sv
// Bring-up/recovery sequencer for one TDL channel: DP resets, then full resets, then latched fault.
// Latency: pins reach the FSM 2 cycles after capture; all outputs registered (one more cycle).
// Backpressure: none; a restart edge overrides any transition.
module tdl_link_sequencer
    import tdl_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES     = TDL_RESET_CYCLES,
    parameter int unsigned DP_RESET_CYCLES  = TDL_DP_RESET_CYCLES,
    parameter int unsigned LINK_TIMEOUT     = TDL_LINK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES    = TDL_STABLE_CYCLES,
    parameter int unsigned MAX_DP_RETRIES   = TDL_MAX_DP_RETRIES,
    parameter int unsigned MAX_FULL_RETRIES = TDL_MAX_FULL_RETRIES,
    parameter int unsigned LOSS_W           = TDL_LOSS_W
) (
    input  logic                                  i_clk_freerun,
    input  logic                                  i_reset_n,
    input  logic                                  i_restart,
    input  logic                                  i_link_status,
    output logic                                  o_tdl_reset,
    output logic                                  o_reset_rx_datapath,
    output logic                                  o_link_up,
    output logic                                  o_fault,
    output logic [2:0]                            o_state,
    output logic [$clog2(MAX_DP_RETRIES+1)-1:0]   o_dp_retries,
    output logic [$clog2(MAX_FULL_RETRIES+1)-1:0] o_full_retries,
    output logic [LOSS_W-1:0]                     o_loss_count
);

    localparam int unsigned TMR_W  = $clog2(max3(RESET_CYCLES, DP_RESET_CYCLES, LINK_TIMEOUT) + 1);
    localparam int unsigned STB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned DP_W   = $clog2(MAX_DP_RETRIES + 1);
    localparam int unsigned FULL_W = $clog2(MAX_FULL_RETRIES + 1);

    tdl_state_t        r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [STB_W-1:0]  r_stable;
    logic [DP_W-1:0]   r_dp_retries;
    logic [FULL_W-1:0] r_full_retries;
    logic [LOSS_W-1:0] r_loss_count;
    logic              r_tdl_reset;
    logic              r_reset_rx_datapath;
    logic              r_link_up;
    logic              r_fault;

    tdl_state_t        w_state_nxt;
    logic [DP_W-1:0]   w_dp_nxt;
    logic [FULL_W-1:0] w_full_nxt;
    logic              w_loss_inc;
    logic              w_entry;
    logic              w_timed;
    logic              w_restart_edge;
    logic              w_link_s;

    tdl_sync2 #(.EDGE_OUT(1'b1)) u_sync_restart (
        .i_clk   (i_clk_freerun),
        .i_rst_n (i_reset_n),
        .i_async (i_restart),
        .o_sync  (w_restart_edge)
    );

    tdl_sync2 #(.EDGE_OUT(1'b0)) u_sync_link (
        .i_clk   (i_clk_freerun),
        .i_rst_n (i_reset_n),
        .i_async (i_link_status),
        .o_sync  (w_link_s)
    );

    // Next state and retry bookkeeping; restart edge outranks everything
    always_comb begin
        w_state_nxt = r_state;
        w_dp_nxt    = r_dp_retries;
        w_full_nxt  = r_full_retries;
        w_loss_inc  = 1'b0;
        if (w_restart_edge) begin
            w_state_nxt = S_RESET;
            w_dp_nxt    = '0;
            w_full_nxt  = '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_timer == TMR_W'(RESET_CYCLES - 1)) w_state_nxt = S_WAIT_LINK;
                end
                S_WAIT_LINK: begin
                    // Stability completing in the timeout cycle still wins
                    if (w_link_s && (r_stable == STB_W'(STABLE_CYCLES - 1))) begin
                        w_state_nxt = S_LINKED;
                        w_dp_nxt    = '0;
                        w_full_nxt  = '0;
                    end else if (r_timer == TMR_W'(LINK_TIMEOUT - 1)) begin
                        if (r_dp_retries < DP_W'(MAX_DP_RETRIES)) begin
                            w_state_nxt = S_DP_RESET;
                            w_dp_nxt    = r_dp_retries + DP_W'(1);
                        end else if (r_full_retries < FULL_W'(MAX_FULL_RETRIES)) begin
                            w_state_nxt = S_RESET;
                            w_full_nxt  = r_full_retries + FULL_W'(1);
                            w_dp_nxt    = '0;
                        end else begin
                            w_state_nxt = S_FAULT;
                        end
                    end
                end
                S_DP_RESET: begin
                    if (r_timer == TMR_W'(DP_RESET_CYCLES - 1)) w_state_nxt = S_WAIT_LINK;
                end
                S_LINKED: begin
                    if (!w_link_s) begin
                        w_state_nxt = S_WAIT_LINK;
                        w_loss_inc  = 1'b1;
                    end
                end
                S_FAULT: ;
                default: w_state_nxt = S_RESET;
            endcase
        end
        w_entry = w_restart_edge || (w_state_nxt != r_state);
        w_timed = (r_state == S_RESET) || (r_state == S_WAIT_LINK) || (r_state == S_DP_RESET);
    end

    // State, shared timer, stable counter and event counters
    always_ff @(posedge i_clk_freerun or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_RESET;
            r_timer        <= '0;
            r_stable       <= '0;
            r_dp_retries   <= '0;
            r_full_retries <= '0;
            r_loss_count   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_dp_retries   <= w_dp_nxt;
            r_full_retries <= w_full_nxt;
            if (w_entry)      r_timer <= '0;
            else if (w_timed) r_timer <= r_timer + TMR_W'(1);
            if (w_entry || !w_link_s)          r_stable <= '0;
            else if (r_state == S_WAIT_LINK)   r_stable <= r_stable + STB_W'(1);
            if (w_loss_inc && (r_loss_count != '1)) r_loss_count <= r_loss_count + LOSS_W'(1);
        end
    end

    // Registered status/reset outputs decoded from the next state
    always_ff @(posedge i_clk_freerun or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tdl_reset         <= 1'b1;
            r_reset_rx_datapath <= 1'b0;
            r_link_up           <= 1'b0;
            r_fault             <= 1'b0;
        end else begin
            r_tdl_reset         <= (w_state_nxt == S_RESET) || (w_state_nxt == S_FAULT);
            r_reset_rx_datapath <= (w_state_nxt == S_DP_RESET);
            r_link_up           <= (w_state_nxt == S_LINKED);
            r_fault             <= (w_state_nxt == S_FAULT);
        end
    end

    assign o_tdl_reset         = r_tdl_reset;
    assign o_reset_rx_datapath = r_reset_rx_datapath;
    assign o_link_up           = r_link_up;
    assign o_fault             = r_fault;
    assign o_state             = r_state;
    assign o_dp_retries        = r_dp_retries;
    assign o_full_retries      = r_full_retries;
    assign o_loss_count        = r_loss_count;

endmodule

// File: tb/tb_tdl_link_sequencer.sv
module tb_tdl_link_sequencer;

    localparam int P_RST = 8, P_DP = 4, P_TO = 32, P_STB = 5, P_MDP = 2, P_MFULL = 1, P_LW = 8;

    logic clk = 1'b0, reset_n = 1'b0, restart = 1'b0, link_status = 1'b0;
    logic o_tdl_reset, o_reset_rx_datapath, o_link_up, o_fault;
    logic [2:0] o_state;
    logic [1:0] o_dp_retries;
    logic [0:0] o_full_retries;
    logic [P_LW-1:0] o_loss_count;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    tdl_link_sequencer #(
        .RESET_CYCLES(P_RST), .DP_RESET_CYCLES(P_DP), .LINK_TIMEOUT(P_TO),
        .STABLE_CYCLES(P_STB), .MAX_DP_RETRIES(P_MDP), .MAX_FULL_RETRIES(P_MFULL),
        .LOSS_W(P_LW)
    ) dut (
        .i_clk_freerun(clk), .i_reset_n(reset_n), .i_restart(restart),
        .i_link_status(link_status), .o_tdl_reset(o_tdl_reset),
        .o_reset_rx_datapath(o_reset_rx_datapath), .o_link_up(o_link_up),
        .o_fault(o_fault), .o_state(o_state), .o_dp_retries(o_dp_retries),
        .o_full_retries(o_full_retries), .o_loss_count(o_loss_count)
    );

    // Reference model: phase (0 reset,1 wait,2 dp,3 linked,4 fault), time in phase,
    // run of consecutive synchronised ones, retry/loss tallies, pin history for the synchronisers.
    int m_state = 0, m_t = 0, m_run = 0, m_dp = 0, m_full = 0, m_loss = 0, m_nxt = 0;
    bit l0 = 0, l1 = 0, r0 = 0, r1 = 0, r2 = 0, m_ls = 0, m_redge = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_t = 0; m_run = 0; m_dp = 0; m_full = 0; m_loss = 0;
            l0 = 0; l1 = 0; r0 = 0; r1 = 0; r2 = 0;
        end else begin
            m_ls    = l1;
            m_redge = r1 && !r2;
            m_nxt   = m_state;
            if (m_redge) begin
                m_nxt = 0; m_dp = 0; m_full = 0;
            end else begin
                case (m_state)
                    0: if (m_t == P_RST - 1) m_nxt = 1;
                    1: begin
                        if (m_ls && (m_run + 1 == P_STB)) begin
                            m_nxt = 3; m_dp = 0; m_full = 0;
                        end else if (m_t == P_TO - 1) begin
                            if (m_dp < P_MDP) begin m_nxt = 2; m_dp++; end
                            else if (m_full < P_MFULL) begin m_nxt = 0; m_full++; m_dp = 0; end
                            else m_nxt = 4;
                        end
                    end
                    2: if (m_t == P_DP - 1) m_nxt = 1;
                    3: if (!m_ls) begin m_nxt = 1; if (m_loss < 255) m_loss++; end
                    default: ;
                endcase
            end
            if (m_redge || (m_nxt != m_state)) begin m_t = 0; m_run = 0; end
            else begin m_t++; m_run = m_ls ? m_run + 1 : 0; end
            m_state = m_nxt;
            r2 = r1; r1 = r0; r0 = restart;
            l1 = l0; l0 = link_status;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {14'd0, o_state, o_tdl_reset, o_reset_rx_datapath, o_link_up, o_fault,
                o_dp_retries, o_full_retries, o_loss_count};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {14'd0, 3'(m_state), (m_state == 0) || (m_state == 4), m_state == 2,
                m_state == 3, m_state == 4, 2'(m_dp), 1'(m_full), 8'(m_loss)};
    endfunction

    // Advance one clock and compare every output against the model mid-cycle
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("outputs_vs_model", obs_vec(), exp_vec());
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (o_state !== s && n < budget) begin cyc(); n++; end
        chk(tag, 32'(o_state), 32'(s));
    endtask

    // Starts at the negedge where reset_n was released, link_status held at 1
    task automatic bringup();
        for (int k = 0; k <= 13; k++) begin
            chk("bringup_tdl_reset", 32'(o_tdl_reset), 32'(k < P_RST));
            chk("bringup_link_up", 32'(o_link_up), 32'(k == 13));
            chk("bringup_retries", 32'({o_dp_retries, o_full_retries}), 32'd0);
            if (k < 13) cyc();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(o_state), 32'd0);
        chk({tag, "_tdl_reset"}, 32'(o_tdl_reset), 32'd1);
        chk({tag, "_flags"}, 32'({o_reset_rx_datapath, o_link_up, o_fault}), 32'd0);
        chk({tag, "_counters"}, 32'({o_dp_retries, o_full_retries, o_loss_count}), 32'd0);
    endtask

    initial begin
        int rises, highs, tdl_highs, d, u, ones;
        logic prev_rx;

        // Scenario 1: reset values, then bring-up with link permanently good
        link_status = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        bringup();

        // Scenario 2: link dead -> DP, DP, full reset, DP, DP, fault
        link_status = 1'b0;
        rises = 0; highs = 0; tdl_highs = 0;
        for (int i = 0; i < 400 && !o_fault; i++) begin
            prev_rx = o_reset_rx_datapath;
            cyc();
            if (o_reset_rx_datapath && !prev_rx) rises++;
            if (o_reset_rx_datapath) highs++;
            if (o_tdl_reset && !o_fault) tdl_highs++;
        end
        chk("fault_reached", 32'(o_fault), 32'd1);
        chk("dp_pulse_count", 32'(rises), 32'd4);
        chk("dp_pulse_cycles", 32'(highs), 32'(4 * P_DP));
        chk("full_reset_cycles", 32'(tdl_highs), 32'(P_RST));
        chk("fault_retries", 32'({o_dp_retries, o_full_retries}), 32'({2'(P_MDP), 1'(P_MFULL)}));
        for (int i = 0; i < 1000; i++) begin
            link_status = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("fault_held", 32'({o_fault, o_tdl_reset, o_state}), 32'({1'b1, 1'b1, 3'd4}));

        // Scenario 5a: restart from FAULT
        link_status = 1'b1;
        restart = 1'b1; cyc(); restart = 1'b0; cyc();
        chk("restart_fault_still", 32'(o_state), 32'd4);
        cyc();
        chk("restart_fault_state", 32'(o_state), 32'd0);
        chk("restart_fault_retries", 32'({o_dp_retries, o_full_retries}), 32'd0);
        chk("restart_fault_loss", 32'(o_loss_count), 32'd1);

        // Scenario 3: repeated one-to-three cycle link drops, loss count saturates
        wait_state(3'd3, 40, "relink_after_restart");
        for (int i = 0; i < 300; i++) begin
            d = $urandom_range(1, 3);
            u = $urandom_range(9, 14);
            link_status = 1'b0; cyc();
            if (d == 1) link_status = 1'b1;
            cyc();
            chk("drop_still_linked", 32'(o_state), 32'd3);
            if (d == 2) link_status = 1'b1;
            cyc();
            chk("drop_to_wait", 32'(o_state), 32'd1);
            chk("drop_loss_count", 32'(o_loss_count), 32'((i + 2 > 255) ? 255 : i + 2));
            link_status = 1'b1;
            repeat (u) cyc();
        end
        chk("loss_saturated", 32'(o_loss_count), 32'd255);
        chk("linked_after_loop", 32'(o_link_up), 32'd1);

        // Scenario 4: broken runs of ones never complete stability
        link_status = 1'b0;
        repeat (3) cyc();
        for (int s = 0; s < 6; s++) begin
            ones = $urandom_range(1, P_STB - 1);
            link_status = 1'b1;
            repeat (ones) begin cyc(); chk("no_link_short_runs", 32'(o_link_up), 32'd0); end
            link_status = 1'b0;
            cyc();
            chk("no_link_short_runs", 32'(o_link_up), 32'd0);
        end
        link_status = 1'b1;
        wait_state(3'd3, 60, "link_after_pattern");

        // Scenario 5b: restart in the middle of a DP reset pulse
        link_status = 1'b0;
        wait_state(3'd2, 100, "reach_dp_reset");
        link_status = 1'b1;
        restart = 1'b1; cyc(); restart = 1'b0; cyc();
        chk("restart_dp_still", 32'(o_state), 32'd2);
        cyc();
        chk("restart_dp_state", 32'(o_state), 32'd0);
        chk("restart_dp_retries", 32'({o_dp_retries, o_full_retries}), 32'd0);
        chk("restart_dp_loss", 32'(o_loss_count), 32'd255);

        // Scenario 5c: restart edge lands on the stability-complete cycle
        wait_state(3'd1, 20, "reach_wait_link");
        cyc(); cyc();
        restart = 1'b1; cyc(); restart = 1'b0; cyc();
        chk("restart_vs_stable_pre", 32'(o_state), 32'd1);
        cyc();
        chk("restart_vs_stable_state", 32'(o_state), 32'd0);
        chk("restart_vs_stable_link_up", 32'(o_link_up), 32'd0);

        // Scenario 6: asynchronous reset pulse mid-WAIT_LINK, then replay bring-up
        wait_state(3'd1, 20, "reach_wait_again");
        cyc(); cyc();
        #3 reset_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        bringup();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
